// File: rtl/lcu_pipe_pkg.sv
// Shared constants and chunk geometry helpers for the pipelined lookahead-carry unit.
// Optional build macro used by the top: LCU_PIPE_SKID_EN.
package lcu_pipe_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CHUNK_DEF = 4;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int nchunk(input int width, input int chunk);
    return ceil_div(width, chunk);
  endfunction

  function automatic int chunk_lo(input int k, input int chunk);
    return k * chunk;
  endfunction

  // The final chunk is narrower whenever CHUNK does not divide WIDTH.
  function automatic int chunk_width(input int k, input int width, input int chunk);
    int rem;
    rem = width - k * chunk;
    return (rem < chunk) ? rem : chunk;
  endfunction

endpackage

// File: rtl/lcu_pipe_if.sv
// Streaming handshake bundle for lcu_pipe: P/G/CI in, CO out, valid/ready on both sides.
interface lcu_pipe_if
  import lcu_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] P;
  logic [WIDTH-1:0] G;
  logic             CI;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] CO;

  modport master (
    output in_valid, P, G, CI, out_ready,
    input  in_ready, out_valid, CO
  );

  modport slave (
    input  in_valid, P, G, CI, out_ready,
    output in_ready, out_valid, CO
  );

endinterface

// File: rtl/lcu_pipe_stage.sv
// One pipeline stage: ripples carry across chunk STAGE and registers the partial result.
module lcu_pipe_stage
  import lcu_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF,
  parameter int STAGE = 0
) (
  input  logic             CLK,
  input  logic             SRST,
  input  logic             advance,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] co_in,
  input  logic             carry_in,
  output logic             valid_q,
  output logic [WIDTH-1:0] p_q,
  output logic [WIDTH-1:0] g_q,
  output logic [WIDTH-1:0] co_q,
  output logic             carry_q
);

  localparam int LO = chunk_lo(STAGE, CHUNK);
  localparam int CW = chunk_width(STAGE, WIDTH, CHUNK);

  logic [WIDTH-1:0] co_nxt;
  logic             carry_nxt;

  always_comb begin
    co_nxt    = co_in;
    carry_nxt = carry_in;
    for (int i = 0; i < CW; i++) begin
      carry_nxt      = g_in[LO+i] | (p_in[LO+i] & carry_nxt);
      co_nxt[LO+i]   = carry_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (SRST)
      valid_q <= 1'b0;
    else if (advance)
      valid_q <= valid_in;
  end

  // Data of bubble stages is don't-care; the top masks CO with out_valid.
  always_ff @(posedge CLK) begin
    if (advance) begin
      p_q     <= p_in;
      g_q     <= g_in;
      co_q    <= co_nxt;
      carry_q <= carry_nxt;
    end
  end

endmodule

// File: rtl/lcu_pipe.sv
// Pipelined lookahead-carry unit, one CHUNK-bit ripple per stage, global-stall flow control.
// Define LCU_PIPE_SKID_EN to add a 2-entry output skid buffer with a registered in_ready.
module lcu_pipe
  import lcu_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input logic       CLK,
  input logic       SRST,
  lcu_pipe_if.slave bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);

  logic                          advance;
  logic [NCHUNK:0]               v_s;
  logic [NCHUNK:0]               c_s;
  logic [NCHUNK:0][WIDTH-1:0]    p_s;
  logic [NCHUNK:0][WIDTH-1:0]    g_s;
  logic [NCHUNK:0][WIDTH-1:0]    co_s;
  logic                          unused;

  assign v_s[0]  = bus.in_valid;
  assign c_s[0]  = bus.CI;
  assign p_s[0]  = bus.P;
  assign g_s[0]  = bus.G;
  assign co_s[0] = '0;

  for (genvar k = 0; k < NCHUNK; k++) begin : g_stage
    lcu_pipe_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .STAGE (k)
    ) u_stage (
      .CLK      (CLK),
      .SRST     (SRST),
      .advance  (advance),
      .valid_in (v_s[k]),
      .p_in     (p_s[k]),
      .g_in     (g_s[k]),
      .co_in    (co_s[k]),
      .carry_in (c_s[k]),
      .valid_q  (v_s[k+1]),
      .p_q      (p_s[k+1]),
      .g_q      (g_s[k+1]),
      .co_q     (co_s[k+1]),
      .carry_q  (c_s[k+1])
    );
  end

  // Fully resolved by the last stage; the leftover slices and carry are dead ends.
  assign unused = ^{p_s[NCHUNK], g_s[NCHUNK], c_s[NCHUNK]};

`ifdef LCU_PIPE_SKID_EN
  logic [1:0]       cnt;
  logic [1:0]       cnt_nxt;
  logic             rd_ptr;
  logic             wr_ptr;
  logic             in_ready_q;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] mem [2];

  // Pipeline keeps flowing until the skid is full; skid is bypassed when empty.
  assign advance      = in_ready_q;
  assign bus.in_ready = in_ready_q;
  assign pop          = (cnt != 2'd0) && bus.out_ready;
  assign push         = advance && v_s[NCHUNK] && !((cnt == 2'd0) && bus.out_ready);
  assign cnt_nxt      = cnt + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge CLK) begin
    if (SRST) begin
      cnt        <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      cnt        <= cnt_nxt;
      in_ready_q <= (cnt_nxt != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= co_s[NCHUNK];
  end

  assign bus.out_valid = (cnt != 2'd0) || v_s[NCHUNK];
  assign bus.CO        = (cnt != 2'd0) ? mem[rd_ptr] :
                         (v_s[NCHUNK] ? co_s[NCHUNK] : '0);
`else
  assign advance       = !v_s[NCHUNK] || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = v_s[NCHUNK];
  assign bus.CO        = v_s[NCHUNK] ? co_s[NCHUNK] : '0;
`endif

`ifndef SYNTHESIS
  a_in_stable : assert property (@(posedge CLK) disable iff (SRST)
    (bus.in_valid && !bus.in_ready) |=> ($stable(bus.P) && $stable(bus.G) && $stable(bus.CI)));
`endif

endmodule
